// File: rtl/dm_unit.sv
// rtl/dm_unit.sv - data memory responder: word/half/byte loads and stores, address errors, store counter
// Optional store trace: define DM_TRACE_EN.
module dm_unit #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] PC,
   input  logic [31:0] A,
   input  logic [31:0] WD,
   input  logic        DMWE,
   input  logic        DMRE,
   input  logic [2:0]  DMOP,
   output logic [31:0] RD,
   output logic        ADEL,
   output logic        ADES,
   output logic [15:0] WCOUNT
);

   localparam logic [31:0] BYTES = 32'(DEPTH * 4);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] widx;
   logic [31:0]   w;
   logic [31:0]   merged;
   logic [7:0]    b;
   logic [15:0]   h;
   logic          is_byte;
   logic          is_half;
   logic          is_word;
   logic          load_only;
   logic          misaligned;
   logic          out_of_range;
   logic          commit;

   assign widx = A[AW+1:2];
   assign w    = mem[widx];
   assign b    = w[{A[1:0], 3'b000} +: 8];
   assign h    = w[{A[1], 4'b0000} +: 16];

   // Reserved encodings 101-111 fall through to word accesses.
   assign is_byte   = (DMOP == 3'b001) || (DMOP == 3'b011);
   assign is_half   = (DMOP == 3'b010) || (DMOP == 3'b100);
   assign is_word   = !is_byte && !is_half;
   assign load_only = (DMOP == 3'b011) || (DMOP == 3'b100);

   assign misaligned   = (is_word && (A[1:0] != 2'b00)) || (is_half && A[0]);
   assign out_of_range = (A >= BYTES);

   assign ADEL   = DMRE && !DMWE && (misaligned || out_of_range);
   assign ADES   = DMWE && (misaligned || out_of_range || load_only);
   assign commit = DMWE && !ADES;

   always_comb begin
      RD = '0;
      if (DMRE && !ADEL) begin
         unique case (DMOP)
            3'b001:  RD = {{24{b[7]}}, b};
            3'b010:  RD = {{16{h[15]}}, h};
            3'b011:  RD = {24'h0, b};
            3'b100:  RD = {16'h0, h};
            default: RD = w;
         endcase
      end
   end

   always_comb begin
      merged = w;
      if (is_byte)
         merged[{A[1:0], 3'b000} +: 8] = WD[7:0];
      else if (is_half)
         merged[{A[1], 4'b0000} +: 16] = WD[15:0];
      else
         merged = WD;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         WCOUNT <= '0;
      end else if (commit) begin
         mem[widx] <= merged;
         if (WCOUNT != 16'hFFFF)
            WCOUNT <= WCOUNT + 16'd1;
      end
   end

`ifdef DM_TRACE_EN
   always @(posedge clk) begin
      if (reset_n && commit)
         $display("@%h: *%h <= %h", PC, {A[31:2], 2'b00}, merged);
   end
`else
   logic unused_pc;
   assign unused_pc = ^PC;
`endif

endmodule

// File: tb/tb_dm_unit.sv
// tb/tb_dm_unit.sv - randomized self-checking bench for dm_unit against a byte-array reference model
module tb_dm_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] pc, a, wd, rd;
   logic        dmwe, dmre, adel, ades;
   logic [2:0]  dmop;
   logic [15:0] wcount;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] ref_bytes [4096];
   int         ref_wcount;

   dm_unit dut (
      .clk(clk), .reset_n(reset_n), .PC(pc), .A(a), .WD(wd),
      .DMWE(dmwe), .DMRE(dmre), .DMOP(dmop),
      .RD(rd), .ADEL(adel), .ADES(ades), .WCOUNT(wcount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int access_size(input logic [2:0] op);
      if (op == 3'd1 || op == 3'd3) return 1;
      if (op == 3'd2 || op == 3'd4) return 2;
      return 4;
   endfunction

   function automatic logic addr_bad(input logic [31:0] addr, input logic [2:0] op);
      return (addr >= 32'd4096) || ((addr % access_size(op)) != 0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] op);
      logic [31:0] v = 0;
      int sz = access_size(op);
      for (int k = 0; k < sz; k++)
         v = v | (32'(ref_bytes[addr + k]) << (8 * k));
      if (op == 3'd1) v = {{24{v[7]}}, v[7:0]};
      if (op == 3'd2) v = {{16{v[15]}}, v[15:0]};
      return v;
   endfunction

   task automatic ref_clear();
      for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'h00;
      ref_wcount = 0;
   endtask

   // One bus cycle: drive, check combinational outputs mid-cycle, then commit in the model.
   task automatic step(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] data,
                       input logic we, input logic re);
      logic        exp_adel, exp_ades;
      logic [31:0] exp_rd;
      a = addr; dmop = op; wd = data; dmwe = we; dmre = re; pc = $urandom;
      @(negedge clk);
      exp_ades = we && (addr_bad(addr, op) || op == 3'd3 || op == 3'd4);
      exp_adel = re && !we && addr_bad(addr, op);
      exp_rd   = (re && !we && !exp_adel) ? ref_load(addr, op) : 32'h0;
      check("adel", 32'(adel), 32'(exp_adel));
      check("ades", 32'(ades), 32'(exp_ades));
      if (!we) check("rd", rd, exp_rd);
      check("wcount", 32'(wcount), 32'(ref_wcount));
      @(posedge clk);
      if (we && !exp_ades) begin
         for (int k = 0; k < access_size(op); k++)
            ref_bytes[addr + k] = data[8*k +: 8];
         if (ref_wcount < 16'hFFFF) ref_wcount++;
      end
      #1;
      dmwe = 1'b0; dmre = 1'b0;
   endtask

   task automatic probe(input string tag, input logic [31:0] addr, input logic [2:0] op,
                        input logic [31:0] exp_rd);
      a = addr; dmop = op; dmre = 1'b1; dmwe = 1'b0;
      #2;
      check(tag, rd, exp_rd);
      step(addr, op, 32'h0, 1'b0, 1'b1);
   endtask

   logic [31:0] ra;
   logic [2:0]  rop;
   int          sel;

   initial begin
      reset_n = 1'b0; a = 0; wd = 0; dmwe = 0; dmre = 0; dmop = 0; pc = 0;
      ref_clear();
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk); #1;

      probe("reset_rd", 32'h0, 3'd0, 32'h0);
      check("reset_wcount", 32'(wcount), 32'h0);

      step(32'h10, 3'd0, 32'h12345678, 1'b1, 1'b0);
      probe("word_rd", 32'h10, 3'd0, 32'h12345678);
      check("word_wcount", 32'(wcount), 32'd1);

      step(32'h13, 3'd1, 32'h000000AB, 1'b1, 1'b0);
      probe("byte_merge", 32'h10, 3'd0, 32'hAB345678);
      probe("byte_sext", 32'h13, 3'd1, 32'hFFFFFFAB);
      probe("byte_zext", 32'h13, 3'd3, 32'h000000AB);

      step(32'h12, 3'd2, 32'h0000BEEF, 1'b1, 1'b0);
      probe("half_merge", 32'h10, 3'd0, 32'hBEEF5678);
      probe("half_sext", 32'h12, 3'd2, 32'hFFFFBEEF);
      probe("half_zext", 32'h12, 3'd4, 32'h0000BEEF);

      step(32'h22, 3'd0, 32'hCAFEF00D, 1'b1, 1'b0);
      probe("ades_mem", 32'h20, 3'd0, 32'h0);
      check("ades_wcount", 32'(wcount), 32'd3);
      step(32'h11, 3'd2, 32'h0, 1'b0, 1'b1);
      step(32'h1000, 3'd0, 32'h0, 1'b0, 1'b1);
      step(32'h14, 3'd3, 32'h77, 1'b1, 1'b0);
      step(32'h14, 3'd4, 32'h77, 1'b1, 1'b0);

      step(32'hFFC, 3'd0, 32'h01020304, 1'b1, 1'b0);
      probe("top_byte", 32'hFFF, 3'd3, 32'h01);
      probe("top_half", 32'hFFE, 3'd4, 32'h0102);
      step(32'h1000, 3'd1, 32'h5, 1'b1, 1'b0);
      step(32'hFFFF_FFFC, 3'd0, 32'h0, 1'b0, 1'b1);

      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 15);
         if (sel == 0)      ra = $urandom;
         else if (sel == 1) ra = 32'hFF8 + $urandom_range(0, 15);
         else               ra = $urandom_range(0, 63);
         rop = 3'($urandom_range(0, 7));
         sel = $urandom_range(0, 2);
         step(ra, rop, $urandom, sel == 0, sel == 1);
      end

      step(32'h4, 3'd0, 32'h55, 1'b1, 1'b0);
      probe("pre_reset", 32'h4, 3'd0, 32'h55);
      a = 32'h4; dmop = 3'd0; dmre = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      check("async_rd", rd, 32'h0);
      check("async_wcount", 32'(wcount), 32'h0);
      ref_clear();
      a = 32'h8; wd = 32'hDEAD; dmwe = 1'b1; dmre = 1'b0;
      repeat (2) @(posedge clk);
      #2 dmwe = 1'b0;
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      probe("blocked_store", 32'h8, 3'd0, 32'h0);
      check("blocked_wcount", 32'(wcount), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dm_unit.md
Name: dm_unit

Overview:
- Data memory responder for the P4 single-cycle datapath. It is the memory-side end of the DMWE/DMOP control interface driven by the controller.
- Services word, halfword and byte loads and stores against an internal word array. Reads are combinational; writes commit synchronously on the clock edge.
- Flags misaligned and out-of-range accesses, and keeps a committed-store counter for bench observation.

Parameters:
- DEPTH, 1024, number of 32-bit words; byte address space is DEPTH*4.
- AW, 10, word-index width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all writes commit on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- PC  input  32  PC of the current instruction; used only by the trace feature.
- A  input  32  byte address (ALU result).
- WD  input  32  store data (rt value); byte and halfword stores use its low bits.
- DMWE  input  1  store request.
- DMRE  input  1  load request; DMWE and DMRE both high is illegal, and DMWE wins.
- DMOP  input  3  access type:
  - 000 word.
  - 001 signed byte.
  - 010 signed halfword.
  - 011 unsigned byte, load only.
  - 100 unsigned halfword, load only.
  - 101–111 reserved, treated as word.
- RD  output  32  load data, extended per DMOP.
- ADEL  output  1  load address error.
- ADES  output  1  store address error.
- WCOUNT  output  16  count of committed stores.

Behaviour:
- Reset, asynchronous on reset_n low:
  - All DEPTH words clear to 0.
  - WCOUNT clears to 0.
  - RD, ADEL and ADES then reflect the cleared array combinationally: RD=0 unless an error is flagged.
  - Stores are blocked while reset_n is low.
  - Reset asserted mid-cycle discards the pending store; the cleared state wins.
- Addressing:
  - Word index = A[AW+1:2]; byte lane = A[1:0]; half lane = A[1].
  - Out of range when A >= DEPTH*4, compared on all 32 bits with no wrap-around.
- Misalignment:
  - Word access with A[1:0] != 0.
  - Halfword access with A[0] != 0.
  - Byte accesses are never misaligned.
- Error flags, combinational:
  - ADEL = DMRE & ~DMWE & (misaligned | out of range).
  - ADES = DMWE & (misaligned | out of range).
  - DMOP 011 or 100 with DMWE high is a store error: ADES=1.
- Load path, combinational with zero latency:
  - Selected word w; byte b = w[8*lane+7 : 8*lane]; half h = w[16*A[1]+15 : 16*A[1]].
  - RD per DMOP: 000 → w; 001 → sign-extend b; 010 → sign-extend h; 011 → zero-extend b; 100 → zero-extend h.
  - RD = 0 whenever ADEL = 1, or when DMRE = 0.
- Store path, committed at rising clk when DMWE=1 and ADES=0:
  - Word store replaces the whole word.
  - Byte store replaces only lane A[1:0] with WD[7:0].
  - Halfword store replaces only half A[1] with WD[15:0].
  - Unwritten lanes are preserved.
- Store with ADES=1 leaves memory and WCOUNT unchanged.
- WCOUNT increments by 1 on each committed store and saturates at 16'hFFFF.
- Read-during-write to the same address in the same cycle: RD shows the old contents; new data is visible after the edge.
- One store at most per cycle; there is no internal buffering.

Optional Feature:
- Macro: DM_TRACE_EN.
- With the macro defined:
  - Each committed store prints `@%h: *%h <= %h` giving PC, word-aligned byte address {A[31:2],2'b00}, and the full merged 32-bit word after the lane merge.
  - Stores rejected with ADES print nothing.
- Without the macro: no display statements are compiled in, and functionality is identical.

Test Plan:
- Reset then load: reset_n=0→1; DMRE=1, DMOP=000, A=0x0 → RD=0, ADEL=0, WCOUNT=0.
- Word store and readback: DMWE=1, A=0x10, WD=0x12345678, one edge; then DMRE=1, A=0x10 → RD=0x12345678, WCOUNT=1.
- Byte lane merge and extension:
  - After the word above, store byte A=0x13, WD=0x000000AB.
  - Word load at 0x10 → RD=0xAB345678.
  - DMOP=001 load at A=0x13 → RD=0xFFFFFFAB.
  - DMOP=011 load at A=0x13 → RD=0x000000AB.
- Halfword store: A=0x12, WD=0x0000BEEF, DMOP=010.
  - Word load at 0x10 → RD=0xBEEF5678.
  - DMOP=010 load at A=0x12 → RD=0xFFFFBEEF.
  - DMOP=100 load at A=0x12 → RD=0x0000BEEF.
- Address errors:
  - Word store at A=0x22 → ADES=1, memory unchanged, WCOUNT unchanged.
  - Halfword load at A=0x11 → ADEL=1, RD=0.
  - Load at A=0x1000 (DEPTH=1024) → ADEL=1.
  - Store with DMOP=011 → ADES=1.
- Async reset mid-operation: write 0x55 to A=0x4, then pull reset_n low between clock edges → RD at 0x4 reads 0 immediately, WCOUNT=0; a store held during reset is not committed.
